// File: rtl/srflp_cmd_gen.sv
// srflp_cmd_gen: push-button command front-end for the start/stop SR-flop counter.
// Each button is synchronised (two flops), debounced (stable level plus run-length
// counter) and rising-edge detected. A two-state machine turns accepted presses into
// clean one-cycle start/stop commands, never issues a redundant command, and flags
// presses of both buttons accepted in the same cycle (stop wins).
module srflp_cmd_gen #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_btn,
    input  logic stop_btn,
    output logic start,
    output logic stop,
    output logic running,
    output logic conflict
);

    // Channel index 0 is the start button, index 1 is the stop button.
    localparam int CH_START = 0;
    localparam int CH_STOP  = 1;

    // Counter value on which a differing level has persisted for DB_CYCLES samples.
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_ZERO = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [1:0]           raw_s;
    logic [1:0]           s1_q;
    logic [1:0]           s2_q;
    logic [1:0]           db_q;
    logic [1:0]           db_d;
    logic [1:0]           db_dly_q;
    logic [1:0][DB_W-1:0] cnt_q;
    logic [1:0][DB_W-1:0] cnt_d;
    logic [1:0]           rise_s;

    state_t state_q;
    state_t state_d;
    logic   start_q;
    logic   start_d;
    logic   stop_q;
    logic   stop_d;
    logic   conflict_q;
    logic   conflict_d;

    assign raw_s = {stop_btn, start_btn};

    // Two-flop synchronisers for both raw button levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 2'b00;
            s2_q <= 2'b00;
        end else begin
            s1_q <= raw_s;
            s2_q <= s1_q;
        end
    end

    // Debounce next state: accept a new level only after DB_CYCLES differing samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int c = 0; c < 2; c++) begin
            if (s2_q[c] == db_q[c]) begin
                cnt_d[c] = CNT_ZERO;
            end else if (cnt_q[c] == CNT_LAST) begin
                db_d[c]  = s2_q[c];
                cnt_d[c] = CNT_ZERO;
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_ONE;
            end
        end
    end

    // Debounced level, its run-length counter and the one-cycle delayed copy for edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_q     <= 2'b00;
            db_dly_q <= 2'b00;
            cnt_q    <= {2{CNT_ZERO}};
        end else begin
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    // Releases are deliberately ignored; only debounced presses count.
    assign rise_s = db_q & ~db_dly_q;

    // Command state and registered command outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            conflict_q <= conflict_d;
        end
    end

    // Next run state: stop has priority whenever both presses arrive together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s[CH_START] && !rise_s[CH_STOP]) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rise_s[CH_STOP]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command decode: only state-changing presses produce a pulse.
    always_comb begin
        start_d    = 1'b0;
        stop_d     = 1'b0;
        conflict_d = rise_s[CH_START] & rise_s[CH_STOP];
        case (state_q)
            ST_IDLE: begin
                start_d = rise_s[CH_START] & ~rise_s[CH_STOP];
            end
            ST_RUN: begin
                stop_d = rise_s[CH_STOP];
            end
            default: begin
                start_d = 1'b0;
                stop_d  = 1'b0;
            end
        endcase
    end

    assign start    = start_q;
    assign stop     = stop_q;
    assign running  = (state_q == ST_RUN);
    assign conflict = conflict_q;

endmodule

// File: tb/tb_srflp_cmd_gen.sv
// Bench for srflp_cmd_gen: directed scenarios plus random button activity, every
// cycle compared against a window-based behavioural model of the command front-end.
module tb_srflp_cmd_gen;

    localparam int DBC = 4;

    logic clk;
    logic reset;
    logic start_btn;
    logic stop_btn;
    logic start;
    logic stop;
    logic running;
    logic conflict;

    srflp_cmd_gen #(.DB_CYCLES(DBC), .DB_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .start     (start),
        .stop      (stop),
        .running   (running),
        .conflict  (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: the accepted level of a button flips once the last DBC
    // synchronised samples (since reset / last flip) all disagree with it.
    bit [1:0] m_s1, m_s2, m_db, m_dbq;
    bit       m_run, m_start, m_stop, m_conf;
    bit       win0[$];
    bit       win1[$];

    // Window statistics for directed checks.
    int n_start, n_stop, n_conf, first_start, first_stop, step_idx;

    function automatic bit all_diff(input bit q[$], input bit lvl);
        bit r;
        r = (q.size() == DBC);
        foreach (q[i]) if (q[i] == lvl) r = 1'b0;
        return r;
    endfunction

    task automatic model_edge();
        bit r0, r1;
        if (reset) begin
            m_s1 = 2'b00; m_s2 = 2'b00; m_db = 2'b00; m_dbq = 2'b00;
            m_run = 1'b0; m_start = 1'b0; m_stop = 1'b0; m_conf = 1'b0;
            win0.delete(); win1.delete();
        end else begin
            r0 = m_db[0] & ~m_dbq[0];
            r1 = m_db[1] & ~m_dbq[1];
            m_conf  = r0 & r1;
            m_start = !m_run && r0 && !r1;
            m_stop  = m_run && r1;
            if (m_start) m_run = 1'b1;
            else if (m_stop) m_run = 1'b0;
            m_dbq = m_db;
            win0.push_back(m_s2[0]);
            if (win0.size() > DBC) void'(win0.pop_front());
            if (all_diff(win0, m_db[0])) begin m_db[0] = ~m_db[0]; win0.delete(); end
            win1.push_back(m_s2[1]);
            if (win1.size() > DBC) void'(win1.pop_front());
            if (all_diff(win1, m_db[1])) begin m_db[1] = ~m_db[1]; win1.delete(); end
            m_s2 = m_s1;
            m_s1 = {stop_btn, start_btn};
        end
    endtask

    task automatic check_outputs();
        n_vec++;
        assert (start === m_start) else begin n_fail++; $error("FAIL start: observed %b expected %b", start, m_start); end
        n_vec++;
        assert (stop === m_stop) else begin n_fail++; $error("FAIL stop: observed %b expected %b", stop, m_stop); end
        n_vec++;
        assert (running === m_run) else begin n_fail++; $error("FAIL running: observed %b expected %b", running, m_run); end
        n_vec++;
        assert (conflict === m_conf) else begin n_fail++; $error("FAIL conflict: observed %b expected %b", conflict, m_conf); end
        n_vec++;
        assert ((start & stop) === 1'b0) else begin n_fail++; $error("FAIL start_stop_excl: observed %b expected 0", start & stop); end
    endtask

    task automatic clr_stats();
        n_start = 0; n_stop = 0; n_conf = 0; first_start = 0; first_stop = 0; step_idx = 0;
    endtask

    // One clock: drive inputs, advance the model, sample outputs 1 time unit after the edge.
    task automatic step(input bit r, input bit sb, input bit pb);
        reset = r; start_btn = sb; stop_btn = pb;
        model_edge();
        @(posedge clk);
        #1;
        step_idx++;
        check_outputs();
        if (start === 1'b1) begin n_start++; if (first_start == 0) first_start = step_idx; end
        if (stop === 1'b1) begin n_stop++; if (first_stop == 0) first_stop = step_idx; end
        if (conflict === 1'b1) n_conf++;
    endtask

    task automatic run(input int n, input bit r, input bit sb, input bit pb);
        for (int i = 0; i < n; i++) step(r, sb, pb);
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs == exp) else begin n_fail++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); end
    endtask

    initial begin
        int dur;
        bit sb, pb;
        reset = 1'b1; start_btn = 1'b0; stop_btn = 1'b0;

        // Reset state.
        run(2, 1'b1, 1'b0, 1'b0);
        expect_int("reset_running", int'(running), 0);
        run(3, 1'b0, 1'b0, 1'b0);

        // Held start press: one pulse on the 7th edge, running with it.
        clr_stats();
        run(20, 1'b0, 1'b1, 1'b0);
        expect_int("t1_start_count", n_start, 1);
        expect_int("t1_start_edge", first_start, DBC + 3);
        expect_int("t1_stop_count", n_stop, 0);
        expect_int("t1_running", int'(running), 1);
        run(8, 1'b0, 1'b0, 1'b0);

        // Stop glitches of 1, 2, 3 cycles are rejected, then a real stop press.
        clr_stats();
        for (int g = 1; g <= 3; g++) begin
            run(g, 1'b0, 1'b0, 1'b1);
            run(5, 1'b0, 1'b0, 1'b0);
        end
        expect_int("t2_glitch_stops", n_stop, 0);
        expect_int("t2_glitch_running", int'(running), 1);
        clr_stats();
        run(10, 1'b0, 1'b0, 1'b1);
        expect_int("t2_stop_count", n_stop, 1);
        expect_int("t2_stop_edge", first_stop, DBC + 3);
        expect_int("t2_running", int'(running), 0);
        run(8, 1'b0, 1'b0, 1'b0);

        // Bouncy start press: pulse 7 edges after steady 1 is first sampled (step 5).
        clr_stats();
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
        run(12, 1'b0, 1'b1, 1'b0);
        expect_int("t3_start_count", n_start, 1);
        expect_int("t3_start_edge", first_start, 5 + DBC + 2);

        // Redundant start in RUN is ignored.
        clr_stats();
        run(8, 1'b0, 1'b0, 1'b0);
        run(8, 1'b0, 1'b1, 1'b0);
        run(8, 1'b0, 1'b0, 1'b0);
        expect_int("t4_redundant_start", n_start, 0);
        run(10, 1'b0, 1'b0, 1'b1);
        run(8, 1'b0, 1'b0, 1'b0);
        // Redundant stop in IDLE is ignored.
        clr_stats();
        run(10, 1'b0, 1'b0, 1'b1);
        run(8, 1'b0, 1'b0, 1'b0);
        expect_int("t4_redundant_stop", n_stop, 0);

        // Simultaneous presses in IDLE: conflict only.
        clr_stats();
        run(10, 1'b0, 1'b1, 1'b1);
        run(8, 1'b0, 1'b0, 1'b0);
        expect_int("t5_idle_conflict", n_conf, 1);
        expect_int("t5_idle_cmds", n_start + n_stop, 0);
        expect_int("t5_idle_running", int'(running), 0);
        // Simultaneous presses in RUN: conflict with stop on the same edge.
        run(10, 1'b0, 1'b1, 1'b0);
        run(8, 1'b0, 1'b0, 1'b0);
        clr_stats();
        run(10, 1'b0, 1'b1, 1'b1);
        expect_int("t5_run_conflict", n_conf, 1);
        expect_int("t5_run_stop", n_stop, 1);
        expect_int("t5_run_start", n_start, 0);
        expect_int("t5_run_running", int'(running), 0);
        run(8, 1'b0, 1'b0, 1'b0);

        // Reset in RUN with start held: no stop, fresh start 7 edges later.
        run(10, 1'b0, 1'b1, 1'b0);
        clr_stats();
        step(1'b1, 1'b1, 1'b0);
        expect_int("t6_reset_running", int'(running), 0);
        expect_int("t6_reset_stop", n_stop, 0);
        clr_stats();
        run(12, 1'b0, 1'b1, 1'b0);
        expect_int("t6_restart_count", n_start, 1);
        expect_int("t6_restart_edge", first_start, DBC + 3);
        run(8, 1'b0, 1'b0, 1'b0);

        // Random button activity with occasional resets.
        for (int s = 0; s < 80; s++) begin
            dur = $urandom_range(1, 12);
            sb  = 1'($urandom_range(0, 1));
            pb  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) step(1'b1, sb, pb);
            run(dur, 1'b0, sb, pb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/srflp_cmd_gen.md
# srflp_cmd_gen

Command front-end for the start/stop SR-flop counter. It takes two raw, asynchronous, bouncy push-button levels, `start_btn` and `stop_btn`. For each it synchronises, debounces and edge-detects the level, then issues clean single-cycle `start` and `stop` pulses that drive the counter's `start`/`stop` inputs directly. It also tracks the run state, so it never issues a redundant command, and it flags conflicting presses.

## Interface
- `DB_CYCLES`, default 4: number of consecutive cycles a synchronised level must differ from the debounced level before it is accepted; legal range 2..15.
- `DB_W`, default 4: debounce counter width; must satisfy 2^DB_W > DB_CYCLES.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; clears all state on the rising edge of `clk` while high.
- `start_btn`  in  1: raw asynchronous start button level, active-high.
- `stop_btn`  in  1: raw asynchronous stop button level, active-high.
- `start`  out  1: registered one-cycle start command to the counter.
- `stop`  out  1: registered one-cycle stop command to the counter.
- `running`  out  1: registered run state; set with `start`, cleared with `stop`.
- `conflict`  out  1: registered one-cycle flag; both buttons accepted in the same cycle.

## Operation
- Per channel, the synchroniser is two flops, `s1` then `s2`. `s2` is the only version of the button used downstream.
- Per channel, debounce keeps a stable level `db` and a counter `cnt` of width `DB_W`.
  - If `s2 == db`: `cnt` <= 0.
  - If `s2 != db` and `cnt == DB_CYCLES-1`: `db` <= `s2`, `cnt` <= 0.
  - Otherwise: `cnt` <= `cnt`+1.
  - Any return of `s2` to `db` before acceptance restarts the count, so glitches shorter than `DB_CYCLES` cycles are rejected.
- Edge detect: `rise_x` = `db_x` & ~`db_x_q`, where `db_x_q` is `db_x` delayed by one cycle. Falling edges (releases) produce nothing.
- Command state machine, states IDLE (`running`=0) and RUN (`running`=1):
  - IDLE, `rise_start` only: `start` <= 1, go to RUN.
  - RUN, `rise_stop` only: `stop` <= 1, go to IDLE.
  - IDLE, `rise_stop` only: ignored; no pulse, stay in IDLE.
  - RUN, `rise_start` only: ignored; no pulse, stay in RUN.
  - `rise_start` and `rise_stop` in the same cycle: `conflict` <= 1, and stop has priority.
    - In RUN: `stop` <= 1, go to IDLE.
    - In IDLE: no command, stay in IDLE.
- `start` and `stop` are never high in the same cycle, and each is high for exactly one cycle per accepted press.
- A held button yields exactly one command. A new command from that button requires a debounced release followed by a debounced press.

## Timing
- Reset values: `start`=0, `stop`=0, `running`=0, `conflict`=0. All of `s1`, `s2`, `db`, `db_q` and `cnt` reset to 0, and the state machine returns to IDLE.
- Latency from raw input to command: `DB_CYCLES`+3 rising edges, counted from the first edge that samples the new raw level into `s1`. This is 7 edges at default.
  - 2 edges to reach `s2`.
  - `DB_CYCLES` edges to update `db`.
  - 1 edge to register the command.
- `running` changes on the same edge that `start` or `stop` is asserted.
- Reset mid-operation:
  - All commands are squashed and `running` drops to 0 on the reset edge.
  - No `stop` pulse is emitted on reset.
  - A button held through reset is treated as a fresh press once reset deasserts, and issues its command `DB_CYCLES`+3 edges after the first non-reset edge.
- Minimum accepted press or release width: `DB_CYCLES` cycles of stable `s2`.

## Test plan
- Reset, then `start_btn`=1 held for 20 cycles (`DB_CYCLES`=4): exactly one `start` pulse on the 7th edge after the first sampling edge; `running` goes to 1 on that same edge; `stop`=0 throughout.
- In RUN, `stop_btn` raw glitches of 1, 2 and 3 cycles separated by 5 low cycles: no `stop` pulse and `running` stays 1. Then a 10-cycle stop press: one `stop` pulse and `running` goes to 0.
- Bouncy start press (1,0,1,0 each for one cycle, then steady 1): exactly one `start` pulse, occurring 7 edges after the steady 1 is first sampled.
- In RUN, `start_btn` released and pressed again (each phase 8 cycles): no `start` pulse. In IDLE, a `stop_btn` press: no `stop` pulse.
- Both buttons raised on the same edge:
  - In RUN: `conflict`=1 and `stop`=1 on the same edge, `start`=0, `running` goes to 0.
  - In IDLE: `conflict`=1 with no command and `running` stays 0.
- `reset` pulsed for 1 cycle while in RUN with `start_btn` held: `running` goes to 0 with no `stop` pulse; a `start` pulse follows 7 edges after reset deasserts.
